// File: rtl/mem_axi_master_if.sv
// AXI4-Lite channel bundle between mem_axi_master and the system interconnect.
// The master modport is used by mem_axi_master; the slave modport is the interconnect side.
interface mem_axi_master_if;
  // Read address channel
  logic [31:0] axi_araddr;
  logic [2:0]  axi_arprot;
  logic        axi_arvalid;
  logic        axi_arready;
  // Read data channel
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready;
  // Write address channel
  logic [31:0] axi_awaddr;
  logic [2:0]  axi_awprot;
  logic        axi_awvalid;
  logic        axi_awready;
  // Write data channel
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wvalid;
  logic        axi_wready;
  // Write response channel
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;

  modport master (
    output axi_araddr, axi_arprot, axi_arvalid,
    input  axi_arready,
    input  axi_rdata, axi_rresp, axi_rvalid,
    output axi_rready,
    output axi_awaddr, axi_awprot, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wvalid,
    input  axi_wready,
    input  axi_bresp, axi_bvalid,
    output axi_bready
  );

  modport slave (
    input  axi_araddr, axi_arprot, axi_arvalid,
    output axi_arready,
    output axi_rdata, axi_rresp, axi_rvalid,
    input  axi_rready,
    input  axi_awaddr, axi_awprot, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wvalid,
    output axi_wready,
    output axi_bresp, axi_bvalid,
    input  axi_bready
  );
endinterface

// File: rtl/mem_axi_master.sv
// mem_axi_master: turns one MMU physical-address request into a single AXI4-Lite
// read or write transaction and reports completion with a one-cycle pulse.
// Only one transaction is in flight; strobes while busy are dropped and flagged.
module mem_axi_master #(
  parameter logic [2:0]  AXI_PROT = 3'b000,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              request_enable,
  input  logic              req_mode,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              response_enable,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic              protocol_err,
  mem_axi_master_if.master  axi
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    RESP
  } state_t;

  state_t      state_q;
  logic        respEn_q;
  logic [31:0] respData_q;
  logic        respErr_q;
  logic        protoErr_q;
  logic [31:0] araddr_q;
  logic        arvalid_q;
  logic        rready_q;
  logic [31:0] awaddr_q;
  logic        awvalid_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        wvalid_q;
  logic        bready_q;

  // AW and W retire independently; each is done if already dropped or handshaking now
  logic awDone_d;
  logic wDone_d;
  logic unusedRespBits;

  // Per-channel completion, including a handshake happening in the current cycle
  always_comb begin
    awDone_d = !awvalid_q || axi.axi_awready;
    wDone_d  = !wvalid_q  || axi.axi_wready;
  end

  // Only bit 1 of RRESP/BRESP distinguishes OKAY/EXOKAY from SLVERR/DECERR
  assign unusedRespBits = axi.axi_rresp[0] ^ axi.axi_bresp[0];

  // Transaction FSM; every output is a register updated here
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      respEn_q   <= 1'b0;
      respData_q <= 32'h0;
      respErr_q  <= 1'b0;
      protoErr_q <= 1'b0;
      araddr_q   <= 32'h0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awaddr_q   <= 32'h0;
      awvalid_q  <= 1'b0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'h0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
    end else begin
      respEn_q <= 1'b0;
      if (request_enable && (state_q != IDLE)) begin
        protoErr_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (request_enable) begin
            if (req_mode) begin
              awaddr_q  <= req_addr;
              wdata_q   <= req_wdata;
              wstrb_q   <= req_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_REQ;
            end else begin
              araddr_q  <= req_addr;
              arvalid_q <= 1'b1;
              state_q   <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (axi.axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (axi.axi_rvalid) begin
            rready_q   <= 1'b0;
            respData_q <= axi.axi_rresp[1] ? ERR_DATA : axi.axi_rdata;
            respErr_q  <= axi.axi_rresp[1];
            respEn_q   <= 1'b1;
            state_q    <= RESP;
          end
        end
        WR_REQ: begin
          if (awvalid_q && axi.axi_awready) begin
            awvalid_q <= 1'b0;
          end
          if (wvalid_q && axi.axi_wready) begin
            wvalid_q <= 1'b0;
          end
          if (awDone_d && wDone_d) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axi.axi_bvalid) begin
            bready_q   <= 1'b0;
            respData_q <= 32'h0;
            respErr_q  <= axi.axi_bresp[1];
            respEn_q   <= 1'b1;
            state_q    <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign response_enable = respEn_q;
  assign resp_data       = respData_q;
  assign resp_err        = respErr_q;
  assign protocol_err    = protoErr_q;

  assign axi.axi_araddr  = araddr_q;
  assign axi.axi_arprot  = AXI_PROT;
  assign axi.axi_arvalid = arvalid_q;
  assign axi.axi_rready  = rready_q;
  assign axi.axi_awaddr  = awaddr_q;
  assign axi.axi_awprot  = AXI_PROT;
  assign axi.axi_awvalid = awvalid_q;
  assign axi.axi_wdata   = wdata_q;
  assign axi.axi_wstrb   = wstrb_q;
  assign axi.axi_wvalid  = wvalid_q;
  assign axi.axi_bready  = bready_q;

endmodule

// File: tb/tb_mem_axi_master.sv
// Directed bench for mem_axi_master: the bench plays the AXI slave by hand and
// compares outputs 1ns after each rising edge against hand-computed values.
module tb_mem_axi_master;

  logic        clk;
  logic        rstn;
  logic        request_enable;
  logic        req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        response_enable;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        protocol_err;

  int checkCount;
  int failCount;

  mem_axi_master_if axiIf ();

  mem_axi_master dut (
    .clk             (clk),
    .rstn            (rstn),
    .request_enable  (request_enable),
    .req_mode        (req_mode),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_wstrb       (req_wstrb),
    .response_enable (response_enable),
    .resp_data       (resp_data),
    .resp_err        (resp_err),
    .protocol_err    (protocol_err),
    .axi             (axiIf)
  );

  // Free-running 10ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Hold a request strobe for exactly one cycle; returns in cycle 1 of the transaction
  task automatic applyStimulus(input logic mode, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb);
    request_enable = 1'b1;
    req_mode       = mode;
    req_addr       = addr;
    req_wdata      = wdata;
    req_wstrb      = wstrb;
    tick();
    request_enable = 1'b0;
  endtask

  task automatic setSlave(input logic arready, input logic rvalid, input logic [31:0] rdata,
                          input logic [1:0] rresp, input logic awready, input logic wready,
                          input logic bvalid, input logic [1:0] bresp);
    axiIf.axi_arready = arready;
    axiIf.axi_rvalid  = rvalid;
    axiIf.axi_rdata   = rdata;
    axiIf.axi_rresp   = rresp;
    axiIf.axi_awready = awready;
    axiIf.axi_wready  = wready;
    axiIf.axi_bvalid  = bvalid;
    axiIf.axi_bresp   = bresp;
  endtask

  initial begin
    checkCount     = 0;
    failCount      = 0;
    rstn           = 1'b0;
    request_enable = 1'b0;
    req_mode       = 1'b0;
    req_addr       = 32'h0;
    req_wdata      = 32'h0;
    req_wstrb      = 4'h0;
    setSlave(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);

    // Reset state
    tick();
    tick();
    checkOutput("rst_arvalid", {31'h0, axiIf.axi_arvalid}, 32'h0);
    checkOutput("rst_awvalid", {31'h0, axiIf.axi_awvalid}, 32'h0);
    checkOutput("rst_wvalid",  {31'h0, axiIf.axi_wvalid},  32'h0);
    checkOutput("rst_readies", {29'h0, axiIf.axi_rready, axiIf.axi_bready, response_enable}, 32'h0);
    checkOutput("rst_errs",    {30'h0, resp_err, protocol_err}, 32'h0);
    checkOutput("rst_data",    resp_data, 32'h0);
    checkOutput("rst_araddr",  axiIf.axi_araddr, 32'h0);
    checkOutput("rst_awaddr",  axiIf.axi_awaddr, 32'h0);
    checkOutput("rst_wdata",   axiIf.axi_wdata, 32'h0);
    checkOutput("rst_wstrb",   {28'h0, axiIf.axi_wstrb}, 32'h0);
    rstn = 1'b1;
    tick();

    // Minimum-latency read
    setSlave(1'b1, 1'b1, 32'hCAFE_BABE, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b0, 32'h8000_1004, 32'h0, 4'hF);
    checkOutput("rd1_c1_arvalid", {31'h0, axiIf.axi_arvalid}, 32'h1);
    checkOutput("rd1_c1_araddr",  axiIf.axi_araddr, 32'h8000_1004);
    checkOutput("rd1_c1_arprot",  {29'h0, axiIf.axi_arprot}, 32'h0);
    checkOutput("rd1_c1_resp",    {31'h0, response_enable}, 32'h0);
    checkOutput("rd1_c1_wstrb",   {28'h0, axiIf.axi_wstrb}, 32'h0);
    tick();
    checkOutput("rd1_c2_arvalid", {31'h0, axiIf.axi_arvalid}, 32'h0);
    checkOutput("rd1_c2_rready",  {31'h0, axiIf.axi_rready}, 32'h1);
    checkOutput("rd1_c2_resp",    {31'h0, response_enable}, 32'h0);
    tick();
    checkOutput("rd1_c3_resp",    {31'h0, response_enable}, 32'h1);
    checkOutput("rd1_c3_data",    resp_data, 32'hCAFE_BABE);
    checkOutput("rd1_c3_err",     {31'h0, resp_err}, 32'h0);
    checkOutput("rd1_c3_rready",  {31'h0, axiIf.axi_rready}, 32'h0);
    tick();
    checkOutput("rd1_c4_resp",    {31'h0, response_enable}, 32'h0);
    checkOutput("rd1_c4_data",    resp_data, 32'hCAFE_BABE);

    // Write with W accepted before AW and a delayed B
    setSlave(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b1, 32'h8000_2000, 32'h1234_5678, 4'b0011);
    checkOutput("wr1_c1_awvalid", {31'h0, axiIf.axi_awvalid}, 32'h1);
    checkOutput("wr1_c1_wvalid",  {31'h0, axiIf.axi_wvalid}, 32'h1);
    checkOutput("wr1_c1_awaddr",  axiIf.axi_awaddr, 32'h8000_2000);
    checkOutput("wr1_c1_wdata",   axiIf.axi_wdata, 32'h1234_5678);
    checkOutput("wr1_c1_wstrb",   {28'h0, axiIf.axi_wstrb}, 32'h3);
    axiIf.axi_wready = 1'b1;
    tick();
    axiIf.axi_wready = 1'b0;
    checkOutput("wr1_c2_wvalid",  {31'h0, axiIf.axi_wvalid}, 32'h0);
    checkOutput("wr1_c2_awvalid", {31'h0, axiIf.axi_awvalid}, 32'h1);
    checkOutput("wr1_c2_bready",  {31'h0, axiIf.axi_bready}, 32'h0);
    tick();
    checkOutput("wr1_c3_awvalid", {31'h0, axiIf.axi_awvalid}, 32'h1);
    checkOutput("wr1_c3_awaddr",  axiIf.axi_awaddr, 32'h8000_2000);
    tick();
    axiIf.axi_awready = 1'b1;
    checkOutput("wr1_c4_bready",  {31'h0, axiIf.axi_bready}, 32'h0);
    tick();
    axiIf.axi_awready = 1'b0;
    checkOutput("wr1_c5_awvalid", {31'h0, axiIf.axi_awvalid}, 32'h0);
    checkOutput("wr1_c5_bready",  {31'h0, axiIf.axi_bready}, 32'h1);
    tick();
    checkOutput("wr1_c6_resp",    {31'h0, response_enable}, 32'h0);
    axiIf.axi_bvalid = 1'b1;
    axiIf.axi_bresp  = 2'b00;
    tick();
    axiIf.axi_bvalid = 1'b0;
    checkOutput("wr1_c7_resp",    {31'h0, response_enable}, 32'h1);
    checkOutput("wr1_c7_data",    resp_data, 32'h0);
    checkOutput("wr1_c7_err",     {31'h0, resp_err}, 32'h0);
    checkOutput("wr1_c7_bready",  {31'h0, axiIf.axi_bready}, 32'h0);
    tick();
    checkOutput("wr1_c8_resp",    {31'h0, response_enable}, 32'h0);

    // Read returning SLVERR: data replaced by ERR_DATA
    setSlave(1'b1, 1'b1, 32'hFFFF_FFFF, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b0, 32'h0000_0100, 32'h0, 4'h0);
    tick();
    tick();
    checkOutput("rderr_resp", {31'h0, response_enable}, 32'h1);
    checkOutput("rderr_data", resp_data, 32'h0);
    checkOutput("rderr_err",  {31'h0, resp_err}, 32'h1);
    tick();

    // Write returning DECERR
    setSlave(1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 1'b1, 2'b11);
    applyStimulus(1'b1, 32'h0000_0200, 32'hA5A5_A5A5, 4'hF);
    tick();
    tick();
    checkOutput("wrerr_resp",  {31'h0, response_enable}, 32'h1);
    checkOutput("wrerr_data",  resp_data, 32'h0);
    checkOutput("wrerr_err",   {31'h0, resp_err}, 32'h1);
    checkOutput("wrerr_proto", {31'h0, protocol_err}, 32'h0);
    tick();

    // Strobes while busy in RD_DATA and in RESP are dropped and flagged
    setSlave(1'b1, 1'b0, 32'h1111_2222, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b0, 32'h0000_0300, 32'h0, 4'h0);
    checkOutput("busy_c1_arvalid", {31'h0, axiIf.axi_arvalid}, 32'h1);
    tick();
    checkOutput("busy_c2_rready",  {31'h0, axiIf.axi_rready}, 32'h1);
    applyStimulus(1'b0, 32'h0000_0400, 32'h0, 4'h0);
    checkOutput("busy_c3_proto",   {31'h0, protocol_err}, 32'h1);
    checkOutput("busy_c3_arvalid", {31'h0, axiIf.axi_arvalid}, 32'h0);
    checkOutput("busy_c3_araddr",  axiIf.axi_araddr, 32'h0000_0300);
    axiIf.axi_rvalid = 1'b1;
    tick();
    axiIf.axi_rvalid = 1'b0;
    checkOutput("busy_c4_resp",    {31'h0, response_enable}, 32'h1);
    checkOutput("busy_c4_data",    resp_data, 32'h1111_2222);
    applyStimulus(1'b0, 32'h0000_0500, 32'h0, 4'h0);
    checkOutput("busy_c5_resp",    {31'h0, response_enable}, 32'h0);
    checkOutput("busy_c5_arvalid", {31'h0, axiIf.axi_arvalid}, 32'h0);
    tick();
    checkOutput("busy_c6_arvalid", {31'h0, axiIf.axi_arvalid}, 32'h0);
    checkOutput("busy_c6_proto",   {31'h0, protocol_err}, 32'h1);

    // Reset while waiting in RD_DATA abandons the read
    setSlave(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b0, 32'h0000_0600, 32'h0, 4'h0);
    tick();
    checkOutput("rstmid_c2_rready", {31'h0, axiIf.axi_rready}, 32'h1);
    checkOutput("rstmid_c2_proto",  {31'h0, protocol_err}, 32'h1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    checkOutput("rstmid_c3_rready",  {31'h0, axiIf.axi_rready}, 32'h0);
    checkOutput("rstmid_c3_arvalid", {31'h0, axiIf.axi_arvalid}, 32'h0);
    checkOutput("rstmid_c3_resp",    {31'h0, response_enable}, 32'h0);
    checkOutput("rstmid_c3_proto",   {31'h0, protocol_err}, 32'h0);
    axiIf.axi_rvalid = 1'b1;
    axiIf.axi_rdata  = 32'hDEAD_DEAD;
    tick();
    checkOutput("rstmid_c4_resp",    {31'h0, response_enable}, 32'h0);
    checkOutput("rstmid_c4_rready",  {31'h0, axiIf.axi_rready}, 32'h0);
    setSlave(1'b1, 1'b1, 32'hABCD_0123, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, 4'h0);
    checkOutput("rstmid_new_araddr", axiIf.axi_araddr, 32'h0000_0040);
    tick();
    tick();
    checkOutput("rstmid_new_resp",   {31'h0, response_enable}, 32'h1);
    checkOutput("rstmid_new_data",   resp_data, 32'hABCD_0123);
    tick();

    // Back-to-back read, write, read with the next strobe right after each pulse
    setSlave(1'b1, 1'b1, 32'h0BAD_F00D, 2'b00, 1'b1, 1'b1, 1'b1, 2'b00);
    applyStimulus(1'b0, 32'h0000_1000, 32'h0, 4'h0);
    tick();
    tick();
    checkOutput("b2b_rd1_resp", {31'h0, response_enable}, 32'h1);
    checkOutput("b2b_rd1_data", resp_data, 32'h0BAD_F00D);
    tick();
    checkOutput("b2b_gap1_resp", {31'h0, response_enable}, 32'h0);
    applyStimulus(1'b1, 32'h0000_2000, 32'h7777_8888, 4'b1100);
    checkOutput("b2b_wr_awaddr", axiIf.axi_awaddr, 32'h0000_2000);
    checkOutput("b2b_wr_wdata",  axiIf.axi_wdata, 32'h7777_8888);
    checkOutput("b2b_wr_wstrb",  {28'h0, axiIf.axi_wstrb}, 32'hC);
    tick();
    tick();
    checkOutput("b2b_wr_resp",  {31'h0, response_enable}, 32'h1);
    checkOutput("b2b_wr_data",  resp_data, 32'h0);
    checkOutput("b2b_wr_err",   {31'h0, resp_err}, 32'h0);
    tick();
    checkOutput("b2b_gap2_resp", {31'h0, response_enable}, 32'h0);
    axiIf.axi_rdata = 32'h5555_AAAA;
    applyStimulus(1'b0, 32'h0000_3000, 32'h0, 4'h0);
    checkOutput("b2b_rd2_araddr", axiIf.axi_araddr, 32'h0000_3000);
    tick();
    tick();
    checkOutput("b2b_rd2_resp", {31'h0, response_enable}, 32'h1);
    checkOutput("b2b_rd2_data", resp_data, 32'h5555_AAAA);
    checkOutput("b2b_proto",    {31'h0, protocol_err}, 32'h0);
    tick();
    checkOutput("b2b_end_resp", {31'h0, response_enable}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
